picmicro_timer1_peripheral: RTL and testbench
=============================================

PICMICRO_TIMER1_PERIPHERAL -- requirements
Module: picmicro_timer1_peripheral

Interface
REQ-001 SHALL have no parameters; addresses are fixed: TMR1L=9'h00E, TMR1H=9'h00F, T1CON=9'h010 (bank 0 only, no mirrors).
REQ-002 clk  input  1  single clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 extern_peripherals_addr  input  9  register-file address driven by the core.
REQ-005 extern_peripherals_data_in  input  8  write data from the core (ALU result).
REQ-006 extern_peripherals_wr_en  input  1  write strobe; one clk wide per write.
REQ-007 extern_peripherals_data_out  output  8  read data returned to the core.
REQ-008 extern_peripherals_hit  output  1  high when addr matches one of the three registers.
REQ-009 instr_cycle_tick  input  1  one-clk pulse per instruction cycle (Fosc/4 source).
REQ-010 t1ckin  input  1  asynchronous external clock pin.
REQ-011 tmr1_overflow  output  1  one-clk pulse on 16-bit wrap, for PIR1.TMR1IF.

Function
REQ-012 T1CON layout: [7:6] read 0, [5:4] T1CKPS, [3] T1OSCEN, [2] T1SYNC_n, [1] TMR1CS, [0] TMR1ON; bits 3 and 2 are stored and read back only, with no other effect.
REQ-013 data_out SHALL be combinational: TMR1L, TMR1H, or {2'b00,T1CON[5:0]} by address; 8'h00 and hit=0 otherwise.
REQ-014 Write: when wr_en=1 and the address hits, the addressed register SHALL load data_in on that clk edge; writes to non-hit addresses are ignored.
REQ-015 t1ckin SHALL pass through a 2-flop synchronizer; an external event is a 0->1 transition of the synchronized signal (edge detect flop), i.e. 3 clk latency pin->event.
REQ-016 Source event = TMR1CS ? external event : instr_cycle_tick; events are counted only while TMR1ON=1.
REQ-017 3-bit prescaler counter increments per counted event; when it equals ratio-1 (ratio 1,2,4,8 for T1CKPS 0..3) it SHALL wrap to 0 and increment TMR1 by 1 in the same clk.
REQ-018 TMR1 = {TMR1H,TMR1L}, 16-bit, wraps 16'hFFFF->16'h0000; tmr1_overflow SHALL be 1 in exactly the clk following the edge at which TMR1 becomes 0 by increment, else 0.
REQ-019 Any write to TMR1L or TMR1H SHALL clear the prescaler counter.
REQ-020 Write to TMR1L/TMR1H coincident with an increment: the write wins; the written byte takes data_in, the other byte holds, no increment, no overflow.
REQ-021 Write to T1CON SHALL NOT clear the prescaler; a new T1CKPS applies from the next event; if the counter already exceeds the new ratio-1 it continues counting up to 7, wraps to 0 without incrementing TMR1, then proceeds normally.
REQ-022 Clearing TMR1ON freezes TMR1 and the prescaler; the synchronizer keeps running, so an edge during TMR1ON=0 is lost.
REQ-023 Writes SHALL be accepted regardless of TMR1ON.

Reset
REQ-024 rst=0 SHALL asynchronously clear TMR1L, TMR1H, T1CON, the prescaler, synchronizer and edge flops, and tmr1_overflow to 0.
REQ-025 After reset release, no spurious external event is generated if t1ckin is already high (edge flop resets to 0 and sees the synchronized 1 only after 2 clk; this counts as one edge and is the sole permitted event).

Verification
REQ-026 Reset mid-count: TMR1=16'h1234, assert rst -> all reads 8'h00 and overflow 0 immediately, no clk needed.
REQ-027 Internal 1:1: write T1CON=8'h01, 5 ticks -> TMR1L=8'h05; write T1CON=8'h31 (1:8), 16 further ticks -> TMR1L=8'h07.
REQ-028 Overflow: TMR1H=8'hFF, TMR1L=8'hFE, T1CON=8'h01, 2 ticks -> TMR1=16'h0000, single-clk tmr1_overflow pulse, next tick -> 16'h0001.
REQ-029 Write collision: TMR1L=8'h10, T1CON=8'h01, write TMR1L=8'h80 in the same clk as a tick -> TMR1L=8'h80, TMR1H unchanged, prescaler 0.
REQ-030 External clock: T1CON=8'h03, 4 t1ckin pulses (each high >=2 clk, low >=2 clk) -> TMR1L=8'h04; instr_cycle_tick ignored throughout.
REQ-031 Decode: read addr 9'h08E -> data_out 8'h00, hit 0; read T1CON after writing 8'hFF -> 8'h3F.

Source files
------------

// File: rtl/picmicro_timer1_peripheral.sv
// PIC-style Timer1: 16-bit counter with a 1/2/4/8 prescaler and TMR1L/TMR1H/T1CON registers.
// The counter is clocked by the instruction-cycle tick or by a synchronized edge on t1ckin.
module picmicro_timer1_peripheral (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] extern_peripherals_addr,
    input  logic [7:0] extern_peripherals_data_in,
    input  logic       extern_peripherals_wr_en,
    output logic [7:0] extern_peripherals_data_out,
    output logic       extern_peripherals_hit,
    input  logic       instr_cycle_tick,
    input  logic       t1ckin,
    output logic       tmr1_overflow
);

    localparam logic [8:0] ADDR_TMR1L = 9'h00E;
    localparam logic [8:0] ADDR_TMR1H = 9'h00F;
    localparam logic [8:0] ADDR_T1CON = 9'h010;

    logic [15:0] tmr1;
    logic [5:0]  t1con;
    logic [2:0]  presc;
    logic [2:0]  ratio_m1;
    logic        sync1, sync2, edge_q;
    logic        hit_l, hit_h, hit_con;
    logic        wr_l, wr_h, wr_con;
    logic        ext_event, count_en;

    assign hit_l   = (extern_peripherals_addr == ADDR_TMR1L);
    assign hit_h   = (extern_peripherals_addr == ADDR_TMR1H);
    assign hit_con = (extern_peripherals_addr == ADDR_T1CON);
    assign extern_peripherals_hit = hit_l | hit_h | hit_con;

    assign wr_l   = extern_peripherals_wr_en & hit_l;
    assign wr_h   = extern_peripherals_wr_en & hit_h;
    assign wr_con = extern_peripherals_wr_en & hit_con;

    // Rising edge of the synchronized pin; edge_q starts at 0 so a pin already high counts once.
    assign ext_event = sync2 & ~edge_q;
    assign count_en  = t1con[0] & (t1con[1] ? ext_event : instr_cycle_tick);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        extern_peripherals_data_out = 8'h00;
        if (hit_l)
            extern_peripherals_data_out = tmr1[7:0];
        else if (hit_h)
            extern_peripherals_data_out = tmr1[15:8];
        else if (hit_con)
            extern_peripherals_data_out = {2'b00, t1con};
    end

    always_comb begin
        ratio_m1 = 3'd0;
        case (t1con[5:4])
            2'd0: ratio_m1 = 3'd0;
            2'd1: ratio_m1 = 3'd1;
            2'd2: ratio_m1 = 3'd3;
            2'd3: ratio_m1 = 3'd7;
            default: ratio_m1 = 3'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr1          <= 16'h0000;
            t1con         <= 6'h00;
            presc         <= 3'd0;
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            edge_q        <= 1'b0;
            tmr1_overflow <= 1'b0;
        end else begin
            sync1         <= t1ckin;
            sync2         <= sync1;
            edge_q        <= sync2;
            tmr1_overflow <= 1'b0;

            if (wr_con)
                t1con <= extern_peripherals_data_in[5:0];

            // A counter-byte write beats a coincident increment and restarts the prescaler.
            if (wr_l || wr_h) begin
                presc <= 3'd0;
                if (wr_l)
                    tmr1[7:0] <= extern_peripherals_data_in;
                if (wr_h)
                    tmr1[15:8] <= extern_peripherals_data_in;
            end else if (count_en) begin
                if (presc == ratio_m1) begin
                    presc         <= 3'd0;
                    tmr1          <= tmr1 + 16'd1;
                    tmr1_overflow <= (tmr1 == 16'hFFFF);
                end else begin
                    // Past a shrunken ratio the count runs to 7 and wraps without a timer increment.
                    presc <= presc + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_picmicro_timer1_peripheral.sv
// Directed self-checking bench for picmicro_timer1_peripheral.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_picmicro_timer1_peripheral;

    localparam logic [8:0] A_L   = 9'h00E;
    localparam logic [8:0] A_H   = 9'h00F;
    localparam logic [8:0] A_CON = 9'h010;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [8:0] addr = 9'h000;
    logic [7:0] din = 8'h00;
    logic       wr = 1'b0;
    logic [7:0] dout;
    logic       hit;
    logic       tick = 1'b0;
    logic       t1ckin = 1'b0;
    logic       ovf;

    int pass_cnt = 0;
    int total_cnt = 0;

    picmicro_timer1_peripheral dut (
        .clk                         (clk),
        .rst                         (rst),
        .extern_peripherals_addr     (addr),
        .extern_peripherals_data_in  (din),
        .extern_peripherals_wr_en    (wr),
        .extern_peripherals_data_out (dout),
        .extern_peripherals_hit      (hit),
        .instr_cycle_tick            (tick),
        .t1ckin                      (t1ckin),
        .tmr1_overflow               (ovf)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        wr   = 1'b1;
        @(negedge clk);
        wr   = 1'b0;
        addr = 9'h000;
    endtask

    task automatic pulse_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic read_reg(input logic [8:0] a, output logic [7:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        read_reg(A_L, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL reset_tmr1l got %h expected 00", v); else pass_cnt++;
        read_reg(A_H, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL reset_tmr1h got %h expected 00", v); else pass_cnt++;
        read_reg(A_CON, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL reset_t1con got %h expected 00", v); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b expected 0", ovf); else pass_cnt++;
    endtask

    task automatic test_internal;
        logic [7:0] v;
        bus_write(A_CON, 8'h01);
        pulse_ticks(5);
        read_reg(A_L, v);
        total_cnt++; if (v !== 8'h05) $display("FAIL int_1to1 got %h expected 05", v); else pass_cnt++;
        bus_write(A_CON, 8'h31);
        pulse_ticks(16);
        read_reg(A_L, v);
        total_cnt++; if (v !== 8'h07) $display("FAIL int_1to8 got %h expected 07", v); else pass_cnt++;
        read_reg(A_H, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL int_high got %h expected 00", v); else pass_cnt++;
    endtask

    task automatic test_overflow;
        logic [7:0] lo, hi;
        bus_write(A_CON, 8'h00);
        bus_write(A_H, 8'hFF);
        bus_write(A_L, 8'hFE);
        bus_write(A_CON, 8'h01);
        pulse_ticks(1);
        total_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_early got %b expected 0", ovf); else pass_cnt++;
        pulse_ticks(1);
        total_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_pulse got %b expected 1", ovf); else pass_cnt++;
        read_reg(A_L, lo);
        read_reg(A_H, hi);
        total_cnt++; if ({hi, lo} !== 16'h0000) $display("FAIL ovf_wrap got %h expected 0000", {hi, lo}); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_single got %b expected 0", ovf); else pass_cnt++;
        pulse_ticks(1);
        read_reg(A_L, lo);
        read_reg(A_H, hi);
        total_cnt++; if ({hi, lo} !== 16'h0001) $display("FAIL ovf_next got %h expected 0001", {hi, lo}); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_after got %b expected 0", ovf); else pass_cnt++;
    endtask

    task automatic test_collision;
        logic [7:0] v;
        bus_write(A_CON, 8'h00);
        bus_write(A_H, 8'h22);
        bus_write(A_L, 8'h10);
        bus_write(A_CON, 8'h01);
        @(negedge clk);
        addr = A_L; din = 8'h80; wr = 1'b1; tick = 1'b1;
        @(negedge clk);
        wr = 1'b0; tick = 1'b0;
        read_reg(A_L, v);
        total_cnt++; if (v !== 8'h80) $display("FAIL coll_low got %h expected 80", v); else pass_cnt++;
        read_reg(A_H, v);
        total_cnt++; if (v !== 8'h22) $display("FAIL coll_high got %h expected 22", v); else pass_cnt++;
        // 1:2 prescaler: a byte write between two events must restart the prescale count.
        bus_write(A_CON, 8'h11);
        pulse_ticks(1);
        bus_write(A_L, 8'h40);
        pulse_ticks(1);
        read_reg(A_L, v);
        total_cnt++; if (v !== 8'h40) $display("FAIL presc_clear got %h expected 40", v); else pass_cnt++;
        pulse_ticks(1);
        read_reg(A_L, v);
        total_cnt++; if (v !== 8'h41) $display("FAIL presc_resume got %h expected 41", v); else pass_cnt++;
    endtask

    task automatic test_ratio_shrink;
        logic [7:0] v;
        bus_write(A_CON, 8'h31);
        bus_write(A_L, 8'h00);
        pulse_ticks(5);
        bus_write(A_CON, 8'h01);
        pulse_ticks(3);
        read_reg(A_L, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL shrink_runout got %h expected 00", v); else pass_cnt++;
        pulse_ticks(1);
        read_reg(A_L, v);
        total_cnt++; if (v !== 8'h01) $display("FAIL shrink_normal got %h expected 01", v); else pass_cnt++;
    endtask

    task automatic test_external;
        logic [7:0] v;
        bus_write(A_CON, 8'h00);
        bus_write(A_L, 8'h00);
        bus_write(A_H, 8'h00);
        bus_write(A_CON, 8'h03);
        @(negedge clk);
        tick = 1'b1;
        repeat (4) @(negedge clk);
        read_reg(A_L, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL ext_tick_ignored got %h expected 00", v); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            t1ckin = 1'b1;
            repeat (3) @(negedge clk);
            t1ckin = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        tick = 1'b0;
        read_reg(A_L, v);
        total_cnt++; if (v !== 8'h04) $display("FAIL ext_count got %h expected 04", v); else pass_cnt++;
        read_reg(A_H, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL ext_high got %h expected 00", v); else pass_cnt++;
    endtask

    task automatic test_disabled;
        logic [7:0] v;
        bus_write(A_CON, 8'h02);
        t1ckin = 1'b1;
        repeat (6) @(negedge clk);
        bus_write(A_CON, 8'h03);
        repeat (4) @(negedge clk);
        read_reg(A_L, v);
        total_cnt++; if (v !== 8'h04) $display("FAIL off_edge_lost got %h expected 04", v); else pass_cnt++;
        t1ckin = 1'b0;
        bus_write(A_CON, 8'h00);
        pulse_ticks(3);
        bus_write(A_L, 8'h9A);
        read_reg(A_L, v);
        total_cnt++; if (v !== 8'h9A) $display("FAIL off_write got %h expected 9a", v); else pass_cnt++;
    endtask

    task automatic test_decode;
        logic [7:0] v;
        read_reg(9'h08E, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL dec_miss_data got %h expected 00", v); else pass_cnt++;
        total_cnt++; if (hit !== 1'b0) $display("FAIL dec_miss_hit got %b expected 0", hit); else pass_cnt++;
        read_reg(A_CON, v);
        total_cnt++; if (hit !== 1'b1) $display("FAIL dec_con_hit got %b expected 1", hit); else pass_cnt++;
        bus_write(A_CON, 8'hFF);
        read_reg(A_CON, v);
        total_cnt++; if (v !== 8'h3F) $display("FAIL dec_t1con_mask got %h expected 3f", v); else pass_cnt++;
        bus_write(A_CON, 8'h00);
        bus_write(9'h08F, 8'h55);
        read_reg(A_H, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL dec_miss_write got %h expected 00", v); else pass_cnt++;
    endtask

    task automatic test_reset_midcount;
        logic [7:0] v;
        bus_write(A_H, 8'h12);
        bus_write(A_L, 8'h34);
        bus_write(A_CON, 8'h01);
        @(negedge clk);
        #1 rst = 1'b0;
        read_reg(A_L, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL rst_mid_low got %h expected 00", v); else pass_cnt++;
        read_reg(A_H, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL rst_mid_high got %h expected 00", v); else pass_cnt++;
        read_reg(A_CON, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL rst_mid_t1con got %h expected 00", v); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        // Reset landing while the overflow pulse is high must drop it without a clock edge.
        bus_write(A_H, 8'hFF);
        bus_write(A_L, 8'hFF);
        bus_write(A_CON, 8'h01);
        pulse_ticks(1);
        total_cnt++; if (ovf !== 1'b1) $display("FAIL rst_ovf_pre got %b expected 1", ovf); else pass_cnt++;
        #1 rst = 1'b0;
        #1;
        total_cnt++; if (ovf !== 1'b0) $display("FAIL rst_ovf_clear got %b expected 0", ovf); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        test_reset;
        test_internal;
        test_overflow;
        test_collision;
        test_ratio_shrink;
        test_external;
        test_disabled;
        test_decode;
        test_reset_midcount;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
